// File: rtl/wf_pkg.sv
// rtl/wf_pkg.sv - register map, response codes and write-strobe helper for the waveform controller
package wf_pkg;

  // Word offsets of the register map (byte address = offset * 4).
  localparam int REG_CTRL    = 0;
  localparam int REG_CH_SEL  = 1;
  localparam int REG_WF_ADDR = 2;
  localparam int REG_WF_DATA = 3;
  localparam int REG_RD_NUM  = 4;
  localparam int REG_STATUS  = 5;

  // Writing 1 to this CTRL bit clears every channel pointer; it is never stored.
  localparam int CTRL_CLR_BIT = 31;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Byte-lane merge of a write into the current register value.
  function automatic logic [31:0] apply_wstrb(input logic [31:0] cur,
                                              input logic [31:0] wd,
                                              input logic [3:0]  strb);
    logic [31:0] r;
    r = cur;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) r[8*b +: 8] = wd[8*b +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/wf_addr_ptr.sv
// rtl/wf_addr_ptr.sv - per-channel DPBRAM write pointer with load, increment, clear and wrap flag
//   clk, rst      : clock, synchronous active-high reset
//   clr           : clear pointer to 0 (highest priority after reset)
//   load/load_val : load a new pointer value
//   inc           : advance pointer by one, modulo 2^ADDR_W
//   ptr           : current pointer
//   wrap          : high in the cycle an increment rolls all-ones over to 0
module wf_addr_ptr #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_val,
  input  logic              inc,
  output logic [ADDR_W-1:0] ptr,
  output logic              wrap
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      ptr <= '0;
    end else if (load) begin
      ptr <= load_val;
    end else if (inc) begin
      ptr <= ptr + 1'b1;
    end
  end

  // Only an increment that actually takes effect can wrap.
  assign wrap = inc & ~clr & ~load & (&ptr);

endmodule

// File: rtl/axi4_lite_wf_ctrl.sv
// rtl/axi4_lite_wf_ctrl.sv - AXI4-Lite register block driving per-channel waveform DPBRAM writes
//   S_AXI_ACLK, S_AXI_ARESET : clock, synchronous active-high reset
//   S_AXI_AW*/W*/B*          : AXI4-Lite write address, data and response channels
//   S_AXI_AR*/R*             : AXI4-Lite read address and data channels
//   o_wf_mode_start          : per-channel run enable, registered copy of CTRL
//   o_wf_write_en            : one-cycle one-hot DPBRAM write strobe
//   o_wf_write_addr/data     : shared DPBRAM write address and data
//   i_wf_read_data_num       : per-channel sample counts, 32 bits per channel
module axi4_lite_wf_ctrl
  import wf_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5,
  parameter int WF_CH              = 2,
  parameter int WF_ADDR_W          = 10,
  parameter int WF_DATA_W          = 16
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [WF_CH-1:0]                o_wf_mode_start,
  output logic [WF_CH-1:0]                o_wf_write_en,
  output logic [WF_ADDR_W-1:0]            o_wf_write_addr,
  output logic [WF_DATA_W-1:0]            o_wf_write_data,
  input  logic [32*WF_CH-1:0]             i_wf_read_data_num
);

  localparam int OFF_W = C_S_AXI_ADDR_WIDTH - 2;

  // Handshake and response state
  logic        aw_rdy_q;
  logic        ar_rdy_q;
  logic        bvalid_q;
  logic        rvalid_q;
  logic [1:0]  bresp_q;
  logic [1:0]  rresp_q;
  logic [31:0] rdata_q;

  // Register state
  logic [WF_CH-1:0]     ctrl_q;
  logic [WF_CH-1:0]     mode_q;
  logic [WF_CH-1:0]     status_q;
  logic [2:0]           ch_sel_q;
  logic [31:0]          rd_num_q;

  // Strobe outputs
  logic [WF_CH-1:0]     en_q;
  logic [WF_ADDR_W-1:0] waddr_q;
  logic [WF_DATA_W-1:0] wdata_q;

  // Pointer bank
  logic [WF_ADDR_W-1:0] ptr [WF_CH];
  logic [WF_CH-1:0]     wrap;
  logic [WF_CH-1:0]     ptr_load;
  logic [WF_CH-1:0]     ptr_inc;
  logic                 clr_all;

  logic                 wr_hs;
  logic                 rd_hs;
  logic [OFF_W-1:0]     wr_off;
  logic [OFF_W-1:0]     rd_off;
  logic                 ch_ok;
  logic [WF_ADDR_W-1:0] sel_ptr;
  logic [31:0]          num_sel;

  logic [31:0]          ctrl_m;
  logic [31:0]          chsel_m;
  logic [31:0]          ptr_m;

  logic                 do_ctrl;
  logic                 do_chsel;
  logic                 do_addr;
  logic                 do_data;
  logic                 do_status;
  logic                 wr_err;
  logic [WF_CH-1:0]     en_next;
  logic [WF_CH-1:0]     w1c_mask;

  logic [31:0]          rd_val;
  logic                 rd_err;
  logic                 unused_ok;

  assign wr_hs  = aw_rdy_q & S_AXI_AWVALID & S_AXI_WVALID;
  assign rd_hs  = ar_rdy_q & S_AXI_ARVALID;
  assign wr_off = S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
  assign rd_off = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
  assign ch_ok  = (int'(ch_sel_q) < WF_CH);

  // Selected-channel pointer and sample count; both read 0 for an absent channel.
  always_comb begin
    sel_ptr = '0;
    num_sel = '0;
    for (int k = 0; k < WF_CH; k++) begin
      if (ch_sel_q == 3'(k)) begin
        sel_ptr = ptr[k];
        num_sel = i_wf_read_data_num[32*k +: 32];
      end
    end
  end

  // Byte-lane merged write values for the strobe-honouring registers.
  assign ctrl_m  = apply_wstrb(32'(ctrl_q),   S_AXI_WDATA, S_AXI_WSTRB);
  assign chsel_m = apply_wstrb(32'(ch_sel_q), S_AXI_WDATA, S_AXI_WSTRB);
  assign ptr_m   = apply_wstrb(32'(sel_ptr),  S_AXI_WDATA, S_AXI_WSTRB);

  // Write decode
  always_comb begin
    do_ctrl   = 1'b0;
    do_chsel  = 1'b0;
    do_addr   = 1'b0;
    do_data   = 1'b0;
    do_status = 1'b0;
    wr_err    = 1'b0;
    if (wr_hs) begin
      case (wr_off)
        OFF_W'(REG_CTRL):    do_ctrl  = 1'b1;
        OFF_W'(REG_CH_SEL):  do_chsel = 1'b1;
        OFF_W'(REG_WF_ADDR): begin
          do_addr = ch_ok;
          wr_err  = ~ch_ok;
        end
        OFF_W'(REG_WF_DATA): begin
          do_data = ch_ok;
          wr_err  = ~ch_ok;
        end
        OFF_W'(REG_RD_NUM):  wr_err    = ~ch_ok;
        OFF_W'(REG_STATUS):  do_status = 1'b1;
        default:             wr_err    = 1'b1;
      endcase
    end
  end

  assign clr_all  = do_ctrl & ctrl_m[CTRL_CLR_BIT];
  assign w1c_mask = do_status ? S_AXI_WDATA[WF_CH-1:0] : '0;

  always_comb begin
    en_next  = '0;
    ptr_load = '0;
    ptr_inc  = '0;
    for (int k = 0; k < WF_CH; k++) begin
      if (ch_sel_q == 3'(k)) begin
        en_next[k]  = do_data;
        ptr_inc[k]  = do_data;
        ptr_load[k] = do_addr;
      end
    end
  end

  for (genvar k = 0; k < WF_CH; k++) begin : g_ptr
    wf_addr_ptr #(
      .ADDR_W (WF_ADDR_W)
    ) u_ptr (
      .clk      (S_AXI_ACLK),
      .rst      (S_AXI_ARESET),
      .clr      (clr_all),
      .load     (ptr_load[k]),
      .load_val (ptr_m[WF_ADDR_W-1:0]),
      .inc      (ptr_inc[k]),
      .ptr      (ptr[k]),
      .wrap     (wrap[k])
    );
  end

  // Read decode; uses pre-edge register values, so a read colliding with a
  // write to the same register returns the old contents.
  always_comb begin
    rd_val = '0;
    rd_err = 1'b0;
    case (rd_off)
      OFF_W'(REG_CTRL):    rd_val = 32'(ctrl_q);
      OFF_W'(REG_CH_SEL):  rd_val = 32'(ch_sel_q);
      OFF_W'(REG_WF_ADDR): begin
        rd_val = ch_ok ? 32'(sel_ptr) : '0;
        rd_err = ~ch_ok;
      end
      OFF_W'(REG_WF_DATA): rd_val = '0;
      OFF_W'(REG_RD_NUM):  begin
        rd_val = ch_ok ? rd_num_q : '0;
        rd_err = ~ch_ok;
      end
      OFF_W'(REG_STATUS):  rd_val = 32'(status_q);
      default:             rd_err = 1'b1;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      aw_rdy_q <= 1'b0;
      ar_rdy_q <= 1'b0;
      bvalid_q <= 1'b0;
      rvalid_q <= 1'b0;
      bresp_q  <= RESP_OKAY;
      rresp_q  <= RESP_OKAY;
      rdata_q  <= '0;
      ctrl_q   <= '0;
      mode_q   <= '0;
      status_q <= '0;
      ch_sel_q <= '0;
      rd_num_q <= '0;
      en_q     <= '0;
      waddr_q  <= '0;
      wdata_q  <= '0;
    end else begin
      // Ready pulses for one cycle and is not re-armed while a response is pending.
      aw_rdy_q <= S_AXI_AWVALID & S_AXI_WVALID & ~bvalid_q & ~aw_rdy_q;
      ar_rdy_q <= S_AXI_ARVALID & ~rvalid_q & ~ar_rdy_q;

      if (wr_hs) begin
        bvalid_q <= 1'b1;
        bresp_q  <= wr_err ? RESP_SLVERR : RESP_OKAY;
      end else if (bvalid_q && S_AXI_BREADY) begin
        bvalid_q <= 1'b0;
      end

      if (rd_hs) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rd_val;
        rresp_q  <= rd_err ? RESP_SLVERR : RESP_OKAY;
      end else if (rvalid_q && S_AXI_RREADY) begin
        rvalid_q <= 1'b0;
      end

      if (do_ctrl)  ctrl_q   <= ctrl_m[WF_CH-1:0];
      if (do_chsel) ch_sel_q <= chsel_m[2:0];
      mode_q   <= ctrl_q;
      rd_num_q <= ch_ok ? num_sel : '0;

      // A wrap in the same cycle as a clear wins.
      status_q <= (status_q & ~w1c_mask) | wrap;

      en_q <= en_next;
      if (do_data) begin
        waddr_q <= sel_ptr;
        wdata_q <= S_AXI_WDATA[WF_DATA_W-1:0];
      end
    end
  end

  // Responses and the strobe are masked while reset is held so that a
  // transaction interrupted by reset never surfaces.
  assign S_AXI_AWREADY   = aw_rdy_q;
  assign S_AXI_WREADY    = aw_rdy_q;
  assign S_AXI_BVALID    = bvalid_q & ~S_AXI_ARESET;
  assign S_AXI_BRESP     = bresp_q;
  assign S_AXI_ARREADY   = ar_rdy_q;
  assign S_AXI_RVALID    = rvalid_q & ~S_AXI_ARESET;
  assign S_AXI_RRESP     = rresp_q;
  assign S_AXI_RDATA     = rdata_q;
  assign o_wf_mode_start = mode_q;
  assign o_wf_write_en   = en_q & {WF_CH{~S_AXI_ARESET}};
  assign o_wf_write_addr = waddr_q;
  assign o_wf_write_data = wdata_q;

  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0],
                       ctrl_m, chsel_m, ptr_m};

endmodule

// File: tb/tb_axi4_lite_wf_ctrl.sv
// tb/tb_axi4_lite_wf_ctrl.sv - self-checking bench for axi4_lite_wf_ctrl
module tb_axi4_lite_wf_ctrl;

  logic        clk;
  logic        rst;
  logic [4:0]  awaddr;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [4:0]  araddr;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [1:0]  mode;
  logic [1:0]  en;
  logic [9:0]  waddr;
  logic [15:0] wdat;
  logic [63:0] num;

  axi4_lite_wf_ctrl dut (
    .S_AXI_ACLK         (clk),
    .S_AXI_ARESET       (rst),
    .S_AXI_AWADDR       (awaddr),
    .S_AXI_AWPROT       (awprot),
    .S_AXI_AWVALID      (awvalid),
    .S_AXI_AWREADY      (awready),
    .S_AXI_WDATA        (wdata),
    .S_AXI_WSTRB        (wstrb),
    .S_AXI_WVALID       (wvalid),
    .S_AXI_WREADY       (wready),
    .S_AXI_BRESP        (bresp),
    .S_AXI_BVALID       (bvalid),
    .S_AXI_BREADY       (bready),
    .S_AXI_ARADDR       (araddr),
    .S_AXI_ARPROT       (arprot),
    .S_AXI_ARVALID      (arvalid),
    .S_AXI_ARREADY      (arready),
    .S_AXI_RDATA        (rdata),
    .S_AXI_RRESP        (rresp),
    .S_AXI_RVALID       (rvalid),
    .S_AXI_RREADY       (rready),
    .o_wf_mode_start    (mode),
    .o_wf_write_en      (en),
    .o_wf_write_addr    (waddr),
    .o_wf_write_data    (wdat),
    .i_wf_read_data_num (num)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Behavioural model state
  typedef struct {
    logic [1:0]  en;
    logic [9:0]  addr;
    logic [15:0] data;
  } strobe_t;

  strobe_t     exp_q[$];
  logic [9:0]  obs_addr[$];
  logic [1:0]  obs_en[$];
  int          obs_cnt = 0;
  logic [31:0] m_ctrl;
  logic [31:0] m_chsel;
  logic [31:0] m_status;
  logic [31:0] m_ptr[2];
  logic        prev_bv = 1'b0;

  function automatic logic [31:0] merge(input logic [31:0] cur, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] mask;
    mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    return (cur & ~mask) | (d & mask);
  endfunction

  task automatic model_reset();
    m_ctrl = 0; m_chsel = 0; m_status = 0; m_ptr[0] = 0; m_ptr[1] = 0;
  endtask

  // A sample write lands at the channel pointer, then the pointer advances.
  task automatic model_data(input logic [31:0] d);
    strobe_t s;
    int c;
    c = int'(m_chsel);
    s.en = 2'(1 << c);
    s.addr = m_ptr[c][9:0];
    s.data = d[15:0];
    exp_q.push_back(s);
    if (m_ptr[c] == 1023) m_status = m_status | (32'd1 << c);
    m_ptr[c] = (m_ptr[c] + 1) % 1024;
  endtask

  // Compare process: every strobe must be predicted and coincide with BVALID rising.
  always @(negedge clk) begin
    if (en != 2'b00) begin
      obs_cnt++;
      obs_addr.push_back(waddr);
      obs_en.push_back(en);
      if (exp_q.size() == 0) begin
        chk("unexpected_strobe", 32'(en), 32'd0);
      end else begin
        strobe_t e;
        e = exp_q.pop_front();
        chk("strobe_en", 32'(en), 32'(e.en));
        chk("strobe_addr", 32'(waddr), 32'(e.addr));
        chk("strobe_data", 32'(wdat), 32'(e.data));
        chk("strobe_with_bvalid_rise", {30'd0, bvalid, prev_bv}, 32'b10);
      end
    end
    prev_bv = bvalid;
  end

  task automatic wait_sig(input string name, input int which);
    int t;
    t = 0;
    while (t < 50) begin
      if ((which == 0 && awready) || (which == 1 && bvalid) ||
          (which == 2 && arready) || (which == 3 && rvalid)) break;
      @(negedge clk);
      t++;
    end
    if (t >= 50) chk({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp);
    @(negedge clk);
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    wait_sig("awready", 0);
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    wait_sig("bvalid", 1);
    resp = bresp;
    @(negedge clk);
  endtask

  task automatic axi_read(input logic [4:0] a, output logic [31:0] d, output logic [1:0] resp);
    @(negedge clk);
    araddr = a; arvalid = 1'b1;
    wait_sig("arready", 2);
    @(negedge clk);
    arvalid = 1'b0;
    wait_sig("rvalid", 3);
    d = rdata;
    resp = rresp;
    @(negedge clk);
  endtask

  task automatic model_write(input int off, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] got);
    logic [1:0]  er;
    logic [31:0] m;
    logic        ok;
    ok = (m_chsel < 2);
    er = 2'b00;
    case (off)
      0: begin
        m = merge(m_ctrl, d, s);
        m_ctrl = m & 32'h3;
        if (m[31]) begin m_ptr[0] = 0; m_ptr[1] = 0; end
      end
      1: m_chsel = merge(m_chsel, d, s) & 32'h7;
      2: if (ok) m_ptr[m_chsel] = merge(m_ptr[m_chsel], d, s) & 32'h3FF; else er = 2'b10;
      3: if (ok) model_data(d); else er = 2'b10;
      4: if (!ok) er = 2'b10;
      5: m_status = m_status & ~d & 32'h3;
      default: er = 2'b10;
    endcase
    axi_write(5'(off * 4), d, s, got);
    chk($sformatf("bresp_off%0d", off), 32'(got), 32'(er));
    chk($sformatf("strobe_drain_off%0d", off), 32'(exp_q.size()), 32'd0);
    if (off == 0) chk("mode_start", 32'(mode), m_ctrl);
  endtask

  task automatic model_read(input int off, output logic [31:0] got);
    logic [31:0] ev;
    logic [1:0]  er;
    logic [1:0]  gr;
    logic        ok;
    ok = (m_chsel < 2);
    ev = 0;
    er = 2'b00;
    case (off)
      0: ev = m_ctrl;
      1: ev = m_chsel;
      2: if (ok) ev = m_ptr[m_chsel]; else er = 2'b10;
      3: ev = 0;
      4: if (ok) ev = num[32*m_chsel +: 32]; else er = 2'b10;
      5: ev = m_status;
      default: er = 2'b10;
    endcase
    axi_read(5'(off * 4), got, gr);
    chk($sformatf("rdata_off%0d", off), got, ev);
    chk($sformatf("rresp_off%0d", off), 32'(gr), 32'(er));
  endtask

  initial begin
    logic [1:0]  r;
    logic [31:0] d;
    logic [31:0] old_sel;
    int          n0;
    int          k;

    clk = 0; rst = 1;
    awaddr = 0; awprot = 0; awvalid = 0; wdata = 0; wstrb = 0; wvalid = 0; bready = 1;
    araddr = 0; arprot = 0; arvalid = 0; rready = 1;
    num = {32'd99, 32'd1234};
    model_reset();
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_awready", 32'(awready), 0);
    chk("rst_wready", 32'(wready), 0);
    chk("rst_bvalid", 32'(bvalid), 0);
    chk("rst_arready", 32'(arready), 0);
    chk("rst_rvalid", 32'(rvalid), 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_resp", {28'd0, bresp, rresp}, 0);
    chk("rst_wf_outs", {en, mode, waddr, wdat}, 0);
    rst = 0;

    // Load pointer near the top and write across the wrap
    model_write(1, 32'd1, 4'hF, r);
    model_write(2, 32'h3FE, 4'hF, r);
    model_write(3, 32'hA, 4'hF, r);
    model_write(3, 32'hB, 4'hF, r);
    model_write(3, 32'hC, 4'hF, r);
    k = obs_addr.size();
    chk("lit_addr0", (k >= 3) ? 32'(obs_addr[k-3]) : 32'hDEAD, 32'h3FE);
    chk("lit_addr1", (k >= 3) ? 32'(obs_addr[k-2]) : 32'hDEAD, 32'h3FF);
    chk("lit_addr2", (k >= 3) ? 32'(obs_addr[k-1]) : 32'hDEAD, 32'h000);
    chk("lit_en", (k >= 3) ? 32'(obs_en[k-1]) : 32'hDEAD, 32'h2);
    model_read(5, d);
    chk("lit_status", d, 32'h2);
    model_read(2, d);

    // Byte-lane write to the pointer: only lane 0 changes
    model_write(2, 32'h0001_FF55, 4'b0001, r);
    model_read(2, d);
    chk("lit_ptr_strb", d, 32'h055);
    model_write(1, 32'h0000_0006, 4'b0000, r);
    model_read(1, d);

    // STATUS is W1C regardless of WSTRB
    model_write(5, 32'h2, 4'b0000, r);
    model_read(5, d);
    chk("lit_status_clr", d, 32'h0);

    // Simultaneous read and write of CH_SEL: read sees the old value
    old_sel = m_chsel;
    @(negedge clk);
    awaddr = 5'h04; wdata = 32'h0; wstrb = 4'hF; awvalid = 1; wvalid = 1;
    araddr = 5'h04; arvalid = 1;
    wait_sig("coll_awready", 0);
    chk("coll_arready", 32'(arready), 1);
    @(negedge clk);
    awvalid = 0; wvalid = 0; arvalid = 0;
    wait_sig("coll_rvalid", 3);
    chk("coll_rdata_old", rdata, old_sel);
    chk("coll_bvalid", 32'(bvalid), 1);
    m_chsel = 0;
    @(negedge clk);
    model_read(1, d);

    // Absent channel
    model_write(1, 32'd5, 4'hF, r);
    model_write(3, 32'h1234, 4'hF, r);
    chk("lit_bad_bresp", 32'(r), 32'h2);
    model_read(4, d);
    chk("lit_bad_rdnum", d, 0);
    model_read(2, d);
    model_write(2, 32'h10, 4'hF, r);
    model_write(4, 32'h10, 4'hF, r);

    // Unmapped offsets
    model_write(6, 32'hFFFF_FFFF, 4'hF, r);
    model_read(6, d);
    model_read(7, d);

    // Clear pointers and start channel 0, then read sample counts
    model_write(1, 32'd0, 4'hF, r);
    model_write(3, 32'h5, 4'hF, r);
    model_write(3, 32'h6, 4'hF, r);
    model_write(0, 32'h8000_0001, 4'hF, r);
    chk("lit_mode", 32'(mode), 32'h1);
    model_read(2, d);
    chk("lit_ptr0_clr", d, 0);
    model_read(0, d);
    chk("lit_ctrl", d, 32'h1);
    model_read(4, d);
    chk("lit_rdnum", d, 32'd1234);
    model_write(1, 32'd1, 4'hF, r);
    model_read(2, d);
    chk("lit_ptr1_clr", d, 0);
    model_read(4, d);

    // Backpressure on B: second write must wait
    n0 = obs_cnt;
    bready = 0;
    model_data(32'h111);
    @(negedge clk);
    awaddr = 5'h0C; wdata = 32'h111; wstrb = 4'hF; awvalid = 1; wvalid = 1;
    wait_sig("bp_awready1", 0);
    @(negedge clk);
    awvalid = 0; wvalid = 0;
    wait_sig("bp_bvalid1", 1);
    model_data(32'h222);
    wdata = 32'h222; awvalid = 1; wvalid = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_bvalid_hold", 32'(bvalid), 1);
      chk("bp_awready_low", 32'(awready), 0);
    end
    chk("bp_one_strobe", 32'(obs_cnt - n0), 1);
    chk("bp_bresp1", 32'(bresp), 0);
    bready = 1;
    @(negedge clk);
    wait_sig("bp_awready2", 0);
    @(negedge clk);
    awvalid = 0; wvalid = 0;
    wait_sig("bp_bvalid2", 1);
    chk("bp_bresp2", 32'(bresp), 0);
    @(negedge clk);
    chk("bp_two_strobes", 32'(obs_cnt - n0), 2);
    chk("bp_drain", 32'(exp_q.size()), 0);
    model_read(2, d);

    // Reset right after a write handshake: no strobe, no response
    n0 = obs_cnt;
    @(negedge clk);
    awaddr = 5'h0C; wdata = 32'h333; wstrb = 4'hF; awvalid = 1; wvalid = 1;
    wait_sig("rst_awready", 0);
    @(posedge clk);
    #1;
    rst = 1; awvalid = 0; wvalid = 0;
    @(negedge clk);
    chk("midrst_bvalid", 32'(bvalid), 0);
    chk("midrst_en", 32'(en), 0);
    @(negedge clk);
    chk("midrst_bvalid2", 32'(bvalid), 0);
    rst = 0;
    model_reset();
    chk("midrst_no_strobe", 32'(obs_cnt - n0), 0);
    chk("midrst_mode", 32'(mode), 0);
    model_read(0, d);
    model_read(1, d);
    chk("lit_midrst_chsel", d, 0);
    model_read(5, d);
    model_read(2, d);
    model_read(4, d);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
